alu_cmd_issue: RTL and testbench
================================

ALU_CMD_ISSUE -- requirements
Module: alu_cmd_issue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning command FIFO entries (power of two, 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, the reset: asynchronous and active-high.
REQ-004 The block SHALL have port cmd_valid, input, 1 bit, command offered upstream.
REQ-005 The block SHALL have port cmd_ready, output, 1 bit, command can be accepted this cycle.
REQ-006 The block SHALL have ports cmd_op input 3 bits, cmd_a input 4 bits and cmd_b input 4 bits, the ALU opcode and operands.
REQ-007 The block SHALL have ports alu_op output 3 bits, alu_a output 4 bits and alu_b output 4 bits, registered drive of the downstream 4-bit ALU.
REQ-008 The block SHALL have ports alu_result input 4 bits and alu_carry input 1 bit, the combinational ALU return.
REQ-009 The block SHALL have ports rsp_valid output 1 bit and rsp_ready input 1 bit, the response handshake.
REQ-010 The block SHALL have ports rsp_result output 4 bits and rsp_carry output 1 bit, the registered ALU outputs.
REQ-011 The block SHALL have port fifo_count, output, $clog2(DEPTH)+1 bits, current FIFO occupancy.

Function
REQ-012 A command SHALL be accepted on a rising edge where cmd_valid and cmd_ready are both 1, and written to the FIFO tail.
REQ-013 cmd_ready SHALL be 1 iff fifo_count < DEPTH and rst = 0; there is no full-FIFO bypass.
REQ-014 The FSM SHALL have states IDLE, DRIVE and HOLD.
REQ-015 IDLE: if FIFO non-empty, pop the head into alu_op/alu_a/alu_b and go to DRIVE; otherwise stay in IDLE.
REQ-016 DRIVE: capture alu_result into rsp_result and alu_carry into rsp_carry, set rsp_valid=1, go to HOLD; alu_* outputs are held stable throughout DRIVE.
REQ-017 HOLD: rsp_valid, rsp_result and rsp_carry are held stable until rsp_ready=1. On that edge, if the FIFO is non-empty, pop the next command and go to DRIVE with rsp_valid=0; otherwise go to IDLE with rsp_valid=0.
REQ-018 Latency: a command accepted on edge E into an empty FIFO in IDLE SHALL show rsp_valid=1 after edge E+2.
REQ-019 Throughput with rsp_ready held at 1 SHALL be one response per 2 cycles.
REQ-020 Responses SHALL be returned in acceptance order with no loss or duplication.
REQ-021 A push and a pop on the same edge SHALL leave fifo_count unchanged, and both operations take effect.
REQ-022 FIFO pointers SHALL wrap modulo DEPTH.
REQ-023 alu_op, alu_a and alu_b SHALL retain their last values while in IDLE.

Reset
REQ-024 While rst=1, all registers SHALL clear immediately regardless of clk: state=IDLE, pointers=0, fifo_count=0, alu_op=0, alu_a=0, alu_b=0, rsp_valid=0, rsp_result=0, rsp_carry=0, and cmd_ready=0.
REQ-025 Reset asserted mid-operation SHALL discard all queued and in-flight commands, with no response produced for them.
REQ-026 The first command SHALL be accepted no earlier than the first rising edge after rst deasserts.

Configuration
REQ-027 Macro ALU_ZERO_FLAG_EN defined: add output rsp_zero (1 bit), registered in DRIVE as (alu_result == 0), held with rsp_result, reset to 0.
REQ-028 Macro ALU_ZERO_FLAG_EN undefined: port rsp_zero and its register SHALL be absent; all other behaviour is identical.

Verification
REQ-029 Add, op=000, a=9, b=8, rsp_ready=1: response rsp_result=1, rsp_carry=1, arriving 2 edges after acceptance.
REQ-030 Subtract, op=001, a=3, b=5: response rsp_result=14, rsp_carry=1. Then op=111, a=7, b=7: response rsp_result=0, rsp_carry=0.
REQ-031 Six back-to-back commands with rsp_ready=0 and DEPTH=4: exactly 5 accepted, fifo_count=4, cmd_ready=0. Releasing rsp_ready: 5 responses in order, cmd_ready returns to 1 after the first pop.
REQ-032 rst pulsed while in HOLD with 3 queued: outputs zero at once, no stale response after release, and a new op=010, a=12, b=10 yields rsp_result=8.
REQ-033 With ALU_ZERO_FLAG_EN, op=010, a=10, b=5: rsp_result=0, rsp_zero=1. Then op=011, a=10, b=5: rsp_result=15, rsp_zero=0.

Source files
------------

// File: rtl/alu_cmd_issue.sv
// Command FIFO feeding a combinational 4-bit ALU, one command in flight, registered response.
// Optional zero flag on the response is built when ALU_ZERO_FLAG_EN is defined.
module alu_cmd_issue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_op,
    input  logic [3:0]               cmd_a,
    input  logic [3:0]               cmd_b,
    output logic [2:0]               alu_op,
    output logic [3:0]               alu_a,
    output logic [3:0]               alu_b,
    input  logic [3:0]               alu_result,
    input  logic                     alu_carry,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [3:0]               rsp_result,
    output logic                     rsp_carry,
`ifdef ALU_ZERO_FLAG_EN
    output logic                     rsp_zero,
`endif
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   FULL    = (PW+1)'(DEPTH);
    localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    typedef struct packed {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, DRIVE, HOLD} state_t;

    state_t         state;
    cmd_t           mem [DEPTH];
    logic [PW-1:0]  wptr;
    logic [PW-1:0]  rptr;
    cmd_t           head;
    logic           nempty;
    logic           push;
    logic           pop;

    assign head      = mem[rptr];
    assign nempty    = (fifo_count != '0);
    assign cmd_ready = !rst && (fifo_count < FULL);
    assign push      = cmd_valid && cmd_ready;
    // The FSM pops from IDLE, or from HOLD on the response handshake edge.
    assign pop       = nempty && ((state == IDLE) || ((state == HOLD) && rsp_ready));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= '{op: cmd_op, a: cmd_a, b: cmd_b};
                wptr      <= wptr + PTR_ONE;
            end
            if (pop) rptr <= rptr + PTR_ONE;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_ONE;
                2'b01:   fifo_count <= fifo_count - CNT_ONE;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            alu_op     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
`ifdef ALU_ZERO_FLAG_EN
            rsp_zero   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        alu_op <= head.op;
                        alu_a  <= head.a;
                        alu_b  <= head.b;
                        state  <= DRIVE;
                    end
                end
                DRIVE: begin
                    // ALU operands have been stable for a full cycle; sample its result.
                    rsp_result <= alu_result;
                    rsp_carry  <= alu_carry;
`ifdef ALU_ZERO_FLAG_EN
                    rsp_zero   <= (alu_result == 4'd0);
`endif
                    rsp_valid  <= 1'b1;
                    state      <= HOLD;
                end
                HOLD: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (pop) begin
                            alu_op <= head.op;
                            alu_a  <= head.a;
                            alu_b  <= head.b;
                            state  <= DRIVE;
                        end else begin
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Bench for alu_cmd_issue: timing-rule reference model, per-cycle compare, directed literal cases.
module tb_alu_cmd_issue;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = '0;
    logic [3:0] cmd_a = '0;
    logic [3:0] cmd_b = '0;
    logic [2:0] alu_op;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_result;
    logic       alu_carry;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [3:0] rsp_result;
    logic       rsp_carry;
`ifdef ALU_ZERO_FLAG_EN
    logic       rsp_zero;
`endif
    logic [$clog2(DEPTH):0] fifo_count;

    alu_cmd_issue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry),
`ifdef ALU_ZERO_FLAG_EN
        .rsp_zero(rsp_zero),
`endif
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // Downstream ALU: {carry, result}
    function automatic logic [4:0] alu_f(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] r;
        case (op)
            3'd0:    r = {1'b0, a} + {1'b0, b};
            3'd1:    r = {a < b, a - b};
            3'd2:    r = {1'b0, a & b};
            3'd3:    r = {1'b0, a | b};
            3'd4:    r = {1'b0, a ^ b};
            3'd5:    r = {1'b0, ~a};
            3'd6:    r = {a, 1'b0};
            default: r = {1'b0, a ^ b};
        endcase
        return r;
    endfunction

    assign {alu_carry, alu_result} = alu_f(alu_op, alu_a, alu_b);

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: a command popped at edge P shows rsp_valid after edge P+1 and
    // completes at the first later edge with rsp_ready; the head pops as soon as nothing
    // is in flight (a command accepted at edge E is poppable from edge E+1).
    typedef struct {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
    } cmd_s;

    cmd_s       pend[$];
    cmd_s       cur;
    bit         has_cur = 0;
    int         cur_pop = 0;
    int         edge_n = 0;
    int         acc_total = 0;
    logic [2:0] e_op = '0;
    logic [3:0] e_a = '0;
    logic [3:0] e_b = '0;
    logic [3:0] e_res = '0;
    logic       e_carry = 1'b0;
    logic [3:0] log_res[$];
    logic       log_c[$];

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            pend.delete();
            has_cur = 0;
            edge_n  = 0;
            e_op = '0; e_a = '0; e_b = '0; e_res = '0; e_carry = 1'b0;
        end else begin
            bit acc;
            edge_n++;
            acc = cmd_valid && (pend.size() < DEPTH);
            if (has_cur && edge_n >= cur_pop + 2 && rsp_ready) begin
                check("rsp_order", {rsp_result, rsp_carry}, alu_f(cur.op, cur.a, cur.b) & 5'h1f ? {alu_f(cur.op, cur.a, cur.b)[3:0], alu_f(cur.op, cur.a, cur.b)[4]} : 5'd0);
                log_res.push_back(rsp_result);
                log_c.push_back(rsp_carry);
                has_cur = 0;
            end
            if (!has_cur && pend.size() > 0) begin
                cur = pend.pop_front();
                cur_pop = edge_n;
                has_cur = 1;
                e_op = cur.op; e_a = cur.a; e_b = cur.b;
            end
            if (acc) begin
                pend.push_back('{op: cmd_op, a: cmd_a, b: cmd_b});
                acc_total++;
            end
            if (has_cur && edge_n == cur_pop + 1) begin
                logic [4:0] r;
                r = alu_f(cur.op, cur.a, cur.b);
                e_res = r[3:0];
                e_carry = r[4];
            end
        end
    end

    // Per-cycle compare, away from the active edge
    initial forever begin
        @(negedge clk);
        check("cmd_ready", cmd_ready, !rst && (pend.size() < DEPTH));
        check("fifo_count", fifo_count, pend.size());
        check("rsp_valid", rsp_valid, has_cur && (edge_n >= cur_pop + 1));
        check("rsp_result", rsp_result, e_res);
        check("rsp_carry", rsp_carry, e_carry);
        check("alu_op", alu_op, e_op);
        check("alu_a", alu_a, e_a);
        check("alu_b", alu_b, e_b);
`ifdef ALU_ZERO_FLAG_EN
        check("rsp_zero", rsp_zero, (edge_n > 0 || has_cur) ? (e_res == 4'd0 && e_res === rsp_result && (e_op != 3'd0 || e_a != 0 || e_b != 0 || has_cur)) : 1'b0);
`endif
    end

    task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
        @(posedge clk); #1;
    endtask

    task automatic wait_log(input int n);
        int k = 0;
        while (log_res.size() < n && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check("wait_log", log_res.size() >= n, 1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((has_cur || pend.size() > 0) && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check("wait_idle", has_cur || pend.size() > 0, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int a0;
        // reset state
        @(posedge clk); #1;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_cmd_ready", cmd_ready, 0);
        @(posedge clk); #1 rst = 1'b0;

        // add 9+8 -> 1 carry 1, valid two edges after acceptance
        send(3'd0, 4'd9, 4'd8);
        cmd_valid = 1'b0;
        check("add_count", fifo_count, 1);
        @(posedge clk); #1;
        check("add_lat1_valid", rsp_valid, 0);
        check("add_alu_a", alu_a, 9);
        @(posedge clk); #1;
        check("add_lat2_valid", rsp_valid, 1);
        check("add_result", rsp_result, 1);
        check("add_carry", rsp_carry, 1);

        // subtract and op 7
        wait_idle();
        n = log_res.size();
        send(3'd1, 4'd3, 4'd5);
        send(3'd7, 4'd7, 4'd7);
        cmd_valid = 1'b0;
        wait_log(n + 2);
        check("sub_result", log_res[n], 14);
        check("sub_carry", log_c[n], 1);
        check("op7_result", log_res[n+1], 0);
        check("op7_carry", log_c[n+1], 0);

        // fill with rsp_ready low
        wait_idle();
        rsp_ready = 1'b0;
        n = log_res.size();
        a0 = acc_total;
        for (int i = 0; i < 6; i++) send(3'd0, 4'(i + 1), 4'd0);
        cmd_valid = 1'b0;
        check("full_accepted", acc_total - a0, 5);
        check("full_count", fifo_count, 4);
        check("full_ready", cmd_ready, 0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("full_ready_back", cmd_ready, 1);
        check("full_count_after_pop", fifo_count, 3);
        wait_log(n + 5);
        for (int k = 0; k < 5; k++) check("full_order", log_res[n+k], k + 1);
        wait_idle();
        check("full_no_sixth", log_res.size(), n + 5);

        // reset while in HOLD with 3 queued
        rsp_ready = 1'b0;
        send(3'd0, 4'd5, 4'd6);
        send(3'd0, 4'd1, 4'd1);
        send(3'd0, 4'd2, 4'd2);
        send(3'd0, 4'd3, 4'd3);
        cmd_valid = 1'b0;
        check("hold_count", fifo_count, 3);
        check("hold_valid", rsp_valid, 1);
        check("hold_result", rsp_result, 11);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", rsp_valid, 0);
        check("arst_result", rsp_result, 0);
        check("arst_count", fifo_count, 0);
        check("arst_alu_a", alu_a, 0);
        check("arst_ready", cmd_ready, 0);
        @(posedge clk); #1 rst = 1'b0;
        rsp_ready = 1'b1;
        n = log_res.size();
        repeat (6) begin @(posedge clk); #1; end
        check("no_stale_rsp", log_res.size(), n);
        check("no_stale_valid", rsp_valid, 0);
        send(3'd2, 4'd12, 4'd10);
        cmd_valid = 1'b0;
        wait_log(n + 1);
        check("post_rst_and", log_res[n], 8);

`ifdef ALU_ZERO_FLAG_EN
        wait_idle();
        send(3'd2, 4'd10, 4'd5);
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("zero_and_result", rsp_result, 0);
        check("zero_and_flag", rsp_zero, 1);
        wait_idle();
        send(3'd3, 4'd10, 4'd5);
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("zero_or_result", rsp_result, 15);
        check("zero_or_flag", rsp_zero, 0);
`endif

        // randomized traffic with one mid-run reset
        wait_idle();
        for (int i = 0; i < 800; i++) begin
            cmd_valid = ($urandom_range(0, 9) < 6);
            cmd_op    = 3'($urandom);
            cmd_a     = 4'($urandom);
            cmd_b     = 4'($urandom);
            rsp_ready = ($urandom_range(0, 9) < 6);
            if (i == 400) begin
                rst = 1'b1;
                #2 rst = 1'b0;
            end
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_idle();
        repeat (3) begin @(posedge clk); #1; end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
